// File: rtl/check_gen.sv
`default_nettype none
// ============================================================================
// check_gen : flag-check sequencer with pass/fail accumulation per batch run
// Revision  : 1.0
// ============================================================================
module check_gen #(
  parameter int N_CHECK  = 8,
  parameter int RESP_LAT = 2,
  parameter int CW       = $clog2(N_CHECK + 1),
  parameter int IW       = (N_CHECK > 1) ? $clog2(N_CHECK) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [N_CHECK-1:0] ref_pattern_i,
  input  logic               f_check_i,
  output logic               fl_check_o,
  output logic               fl_ref_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [CW-1:0]      pass_cnt_o,
  output logic [CW-1:0]      fail_cnt_o,
  output logic               first_fail_o,
  output logic [IW-1:0]      first_fail_idx_o
);

  localparam int WW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_WAIT   = 3'd3,
    S_EVAL   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [N_CHECK-1:0] r_pat;
  logic [IW-1:0]      r_idx;
  logic [WW-1:0]      r_wcnt;
  logic [CW-1:0]      r_pass;
  logic [CW-1:0]      r_fail;
  logic               r_ff;
  logic [IW-1:0]      r_ff_idx;
  logic               w_last;
  logic               w_wait_end;
  logic               w_match;

  assign w_last     = (r_idx == IW'(N_CHECK - 1));
  assign w_wait_end = (r_wcnt == WW'(RESP_LAT - 1));
  assign w_match    = (f_check_i == r_pat[r_idx]);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_next = S_SETUP;
      S_SETUP:  w_next = S_STROBE;
      S_STROBE: w_next = S_WAIT;
      S_WAIT:   if (w_wait_end) w_next = S_EVAL;
      S_EVAL:   w_next = w_last ? S_DONE : S_SETUP;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Result registers are only touched on start and in EVAL, so they hold after DONE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pat    <= '0;
      r_idx    <= '0;
      r_wcnt   <= '0;
      r_pass   <= '0;
      r_fail   <= '0;
      r_ff     <= 1'b0;
      r_ff_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_pat    <= ref_pattern_i;
            r_idx    <= '0;
            r_pass   <= '0;
            r_fail   <= '0;
            r_ff     <= 1'b0;
            r_ff_idx <= '0;
          end
        end
        S_STROBE: r_wcnt <= '0;
        S_WAIT:   if (!w_wait_end) r_wcnt <= r_wcnt + 1'b1;
        S_EVAL: begin
          if (w_match) begin
            r_pass <= r_pass + 1'b1;
          end else begin
            r_fail <= r_fail + 1'b1;
            if (!r_ff) begin
              r_ff     <= 1'b1;
              r_ff_idx <= r_idx;
            end
          end
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fl_check_o       = (r_state == S_STROBE);
  assign fl_ref_o         = (r_state == S_SETUP || r_state == S_STROBE ||
                             r_state == S_WAIT  || r_state == S_EVAL) ? r_pat[r_idx] : 1'b0;
  assign busy_o           = (r_state != S_IDLE);
  assign done_o           = (r_state == S_DONE);
  assign pass_cnt_o       = r_pass;
  assign fail_cnt_o       = r_fail;
  assign first_fail_o     = r_ff;
  assign first_fail_idx_o = r_ff_idx;

endmodule
`default_nettype wire
